rr_dec_arbiter: RTL and testbench
=================================

// Module: rr_dec_arbiter
// PURPOSE
//  8-way round-robin arbiter that owns the 3-to-8 decoder select path.
//  Picks one requester, drives the decoder enable and 3-bit select, and
//  holds the grant until the owner releases it or a hold timeout fires.
//  Sits between requesting blocks and the shared resource selected by the
//  decoder's one-hot outputs.
// PARAMETERS
//  NREQ      8   number of requesters; fixed at 8 to match the 3-to-8 decode
//  IDXW      3   grant index width, log2(NREQ)
//  MAX_HOLD  15  max grant cycles before forced release; 0 disables timeout
//  CNTW      4   hold counter width; must satisfy 2**CNTW > MAX_HOLD
// PORTS
//  clk      in   1     clock, rising-edge
//  rst      in   1     asynchronous reset, active-high
//  req      in   8     request vector; bit i = requester i
//  done     in   1     current owner releases the grant
//  gnt_en   out  1     decoder enable (registered)
//  gnt_idx  out  3     decoder select, MSB = a, LSB = c (registered)
//  gnt      out  8     one-hot grant; bit i = gnt_en & (gnt_idx == i)
//  busy     out  1     high while in BUSY
//  timeout  out  1     one-cycle pulse on forced release
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, ptr=0, hold_cnt=0, gnt_en=0,
//   gnt_idx=0, gnt=0, busy=0, timeout=0. Asserting rst mid-grant drops
//   gnt at once, without waiting for a clock edge.
//  ptr = highest-priority index. Search order: ptr, ptr+1, ..., wrapping
//   mod 8.
//  FSM states:
//   IDLE: gnt_en=0. If req != 0 at the edge, the first set bit in search
//    order wins. At that edge: gnt_idx=winner, gnt_en=1, hold_cnt=0,
//    state->BUSY. If req==0, stay in IDLE. done is ignored in IDLE.
//   BUSY: hold_cnt increments each cycle, saturating at the counter max.
//    The grant is released at the edge where any of these is true:
//     (a) done=1;
//     (b) req[gnt_idx]=0, i.e. the owner withdrew its request;
//     (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
//    On release: gnt_en=0, ptr=(gnt_idx+1) mod 8 (wraps 7->0),
//     state->IDLE. gnt_idx keeps its last value.
//    timeout=1 for exactly the cycle after a release caused only by (c).
//     If (a) or (b) is true on the same edge, there is no timeout pulse.
//  Latency: req sampled at edge k -> gnt visible after edge k.
//   Release at edge m -> gnt=0 after edge m.
//   Earliest regrant is edge m+1, so there is always at least one dead
//   cycle between grants. Two requesters are never granted at once.
//  Grant length: with MAX_HOLD=N, an uninterrupted grant lasts N cycles.
//  New requests arriving during BUSY wait; they are not pre-empted or
//   queued beyond the req level.
//  gnt is combinational from registers only: no path from req or done
//   to the outputs.
// TESTING
//  1) rst=1, then rst=0, req=0 for 5 cycles -> gnt=0, gnt_en=0, busy=0,
//     timeout=0 throughout.
//  2) req=8'h81 held, done pulsed 2 cycles after each grant -> grants in
//     order idx 0, 7, 0, 7, ...; gnt=01,80,01,80; one dead cycle between.
//  3) req=8'hFF, done pulsed each grant -> idx 0,1,...,7,0: wraps 7->0.
//  4) MAX_HOLD=15, req=8'h04 held, done=0 -> gnt=8'h04 for 15 cycles,
//     timeout=1 for one cycle, then regrant to idx 2 one cycle later.
//  5) done=1 on the same edge as hold_cnt=MAX_HOLD-1 -> release with
//     timeout=0. A separate grant where req[idx] is dropped -> release
//     on the next edge.
//  6) rst asserted mid-grant (gnt=8'h10) -> gnt=0 before the next clock
//     edge. After release, ptr=0 and req=8'h11 grants idx 0.

Source files
------------

// File: rtl/rr_dec_arbiter.sv
// 8-way round-robin arbiter driving a 3-to-8 decoder select. The grant is held
// until the owner releases it with done or drops its request, or the hold timer expires.
module rr_dec_arbiter #(
  parameter int NREQ     = 8,
  parameter int IDXW     = 3,
  parameter int MAX_HOLD = 15,
  parameter int CNTW     = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] req_i,
  input  logic            done_i,
  output logic            gnt_en_o,
  output logic [IDXW-1:0] gnt_idx_o,
  output logic [NREQ-1:0] gnt_o,
  output logic            busy_o,
  output logic            timeout_o
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [CNTW-1:0]   hold_q, hold_d;
  logic              en_q, en_d;
  logic              to_q, to_d;

  logic [IDXW-1:0]   win_idx, cand;
  logic              win_vld;
  logic              rel_ab, rel_c;

  // Walk from the lowest priority back to ptr so the last hit is the first in search order.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int j = NREQ-1; j >= 0; j--) begin
      cand = ptr_q + IDXW'(j);
      if (req_i[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign rel_ab = done_i | ~req_i[idx_q];
  assign rel_c  = (MAX_HOLD != 0) && (hold_q == CNTW'(MAX_HOLD-1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    en_d    = en_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = BUSY;
          idx_d   = win_idx;
          en_d    = 1'b1;
          hold_d  = '0;
        end
      end
      BUSY: begin
        hold_d = (hold_q == '1) ? hold_q : hold_q + 1'b1;
        if (rel_ab || rel_c) begin
          state_d = IDLE;
          en_d    = 1'b0;
          ptr_d   = idx_q + 1'b1;
          // timeout only flags releases the owner did not ask for
          to_d    = rel_c & ~rel_ab;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      en_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      en_q    <= en_d;
      to_q    <= to_d;
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_dec
    assign gnt_o[i] = en_q & (idx_q == IDXW'(i));
  end

  assign gnt_en_o  = en_q;
  assign gnt_idx_o = idx_q;
  assign busy_o    = (state_q == BUSY);
  assign timeout_o = to_q;

endmodule

// File: tb/tb_rr_dec_arbiter.sv
// Bench for rr_dec_arbiter: directed vector table, hand-written corner sequences
// and random traffic, all cross-checked against an owner/ptr reference model.
module tb_rr_dec_arbiter;

  localparam int MAXH = 15;

  logic       clk = 1'b0;
  logic       rst, done;
  logic [7:0] req;
  logic       gnt_en, busy, timeout;
  logic [2:0] gnt_idx;
  logic [7:0] gnt;

  rr_dec_arbiter #(.NREQ(8), .IDXW(3), .MAX_HOLD(MAXH), .CNTW(4)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .done_i(done),
    .gnt_en_o(gnt_en), .gnt_idx_o(gnt_idx), .gnt_o(gnt),
    .busy_o(busy), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // reference model: owner = -1 when nobody holds the grant
  int m_owner = -1, m_ptr = 0, m_last = 0, m_len = 0;
  bit m_to = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void model_edge(logic r, logic [7:0] q, logic d);
    if (r) begin
      m_owner = -1; m_ptr = 0; m_last = 0; m_to = 1'b0; m_len = 0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      for (int j = 0; j < 8; j++) begin
        int k;
        k = (m_ptr + j) % 8;
        if (m_owner < 0 && q[k]) begin
          m_owner = k; m_last = k; m_len = 1;
        end
      end
    end else begin
      bit by_owner, by_time;
      by_owner = d || !q[m_owner];
      by_time  = (MAXH != 0) && (m_len == MAXH);
      if (by_owner || by_time) begin
        m_to    = by_time && !by_owner;
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
      end else begin
        m_to  = 1'b0;
        m_len = m_len + 1;
      end
    end
  endfunction

  function automatic logic [7:0] m_gnt();
    return (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
  endfunction

  task automatic step(input logic r, input logic [7:0] q, input logic d);
    rst = r; req = q; done = d;
    @(posedge clk);
    model_edge(r, q, d);
    #1;
    chk("model_gnt", 32'(gnt), 32'(m_gnt()));
    chk("model_gnt_en", 32'(gnt_en), 32'(m_owner >= 0));
    chk("model_busy", 32'(busy), 32'(m_owner >= 0));
    chk("model_gnt_idx", 32'(gnt_idx), 32'(m_last));
    chk("model_timeout", 32'(timeout), 32'(m_to));
  endtask

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic       to;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic [7:0] q, logic d, logic [7:0] g, logic t);
    vec_t v;
    v.req = q; v.done = d; v.gnt = g; v.to = t;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [7:0] own;
    logic [7:0] rq;

    // alternating 0/7 with done two cycles after each grant
    for (int rep = 0; rep < 2; rep++) begin
      for (int s = 0; s < 2; s++) begin
        own = (s == 0) ? 8'h01 : 8'h80;
        add(8'h81, 1'b0, own, 1'b0);
        add(8'h81, 1'b0, own, 1'b0);
        add(8'h81, 1'b1, 8'h00, 1'b0);
      end
    end
    // all requesting, done held high: walks 0..7 then wraps to 0
    for (int i = 0; i < 9; i++) begin
      add(8'hFF, 1'b1, 8'(1 << (i % 8)), 1'b0);
      add(8'hFF, 1'b1, 8'h00, 1'b0);
    end

    rst = 1'b1; req = 8'h00; done = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_gnt_en", 32'(gnt_en), 32'h0);
    chk("rst_gnt_idx", 32'(gnt_idx), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    step(1'b1, 8'h00, 1'b0);

    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h00, 1'b0);
      chk("idle_gnt", 32'(gnt), 32'h0);
      chk("idle_busy", 32'(busy), 32'h0);
      chk("idle_timeout", 32'(timeout), 32'h0);
    end

    foreach (tbl[i]) begin
      step(1'b0, tbl[i].req, tbl[i].done);
      chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_to", i), 32'(timeout), 32'(tbl[i].to));
    end

    // ptr is 1 here; req 04 alone runs into the hold timeout
    for (int c = 0; c < MAXH; c++) begin
      step(1'b0, 8'h04, 1'b0);
      chk($sformatf("hold_gnt_c%0d", c), 32'(gnt), 32'h04);
      chk("hold_to", 32'(timeout), 32'h0);
    end
    step(1'b0, 8'h04, 1'b0);
    chk("tmo_gnt", 32'(gnt), 32'h00);
    chk("tmo_pulse", 32'(timeout), 32'h1);
    step(1'b0, 8'h04, 1'b0);
    chk("regrant_gnt", 32'(gnt), 32'h04);
    chk("regrant_to", 32'(timeout), 32'h0);

    // done coincides with the last hold cycle: released without timeout
    for (int c = 0; c < MAXH-1; c++) begin
      step(1'b0, 8'h04, 1'b0);
      chk("hold2_gnt", 32'(gnt), 32'h04);
    end
    step(1'b0, 8'h04, 1'b1);
    chk("done_at_max_gnt", 32'(gnt), 32'h00);
    chk("done_at_max_to", 32'(timeout), 32'h0);

    // owner withdraws its request
    step(1'b0, 8'h04, 1'b0);
    chk("wd_grant", 32'(gnt), 32'h04);
    step(1'b0, 8'h00, 1'b0);
    chk("wd_release", 32'(gnt), 32'h00);
    chk("wd_to", 32'(timeout), 32'h0);

    // ptr is 3: an async reset mid-grant must drop gnt and clear ptr
    step(1'b0, 8'h10, 1'b0);
    chk("pre_rst_gnt", 32'(gnt), 32'h10);
    step(1'b0, 8'h10, 1'b0);
    rst = 1'b1;
    #2;
    chk("async_rst_gnt", 32'(gnt), 32'h00);
    chk("async_rst_en", 32'(gnt_en), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    step(1'b1, 8'h11, 1'b0);
    step(1'b0, 8'h11, 1'b0);
    chk("post_rst_gnt", 32'(gnt), 32'h01);
    chk("post_rst_idx", 32'(gnt_idx), 32'h0);

    rq = 8'h00;
    for (int i = 0; i < 800; i++) begin
      logic r, d;
      if ($urandom_range(0, 3) == 0) rq = 8'($urandom);
      d = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 249) == 0);
      step(r, rq, d);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
